// File: rtl/mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                   |
// | Purpose  : Two-port (fetch / data) arbiter in front of a single-ported   |
// |            memory. Data accesses win ties until the fetch port has been |
// |            passed over STARVE_LIMIT times in a row. Each access owns     |
// |            the memory port for LATENCY cycles. Completion is signalled  |
// |            by a one-cycle ack in the cycle after the grant.              |
// | Ports    : clock, reset (async, active-high)                             |
// |            i_req/i_addr -> i_ack/i_rdata       fetch port (word reads)   |
// |            d_req/d_rw/d_addr/d_wdata/d_width/d_signed -> d_ack/d_rdata   |
// |            mem_address/mem_data_in/mem_read_write/mem_width/             |
// |            mem_signed_read -> memory, mem_data_out <- memory             |
// |            busy : high while an access owns the memory port              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif
`ifndef MEM_WIDTH_B
`define MEM_WIDTH_B 2'b00
`endif
`ifndef MEM_WIDTH_H
`define MEM_WIDTH_H 2'b01
`endif
`ifndef MEM_WIDTH_W
`define MEM_WIDTH_W 2'b10
`endif

module mem_arbiter #(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_width,
    input  logic        d_signed,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    output logic [1:0]  mem_width,
    output logic        mem_signed_read,
    input  logic [31:0] mem_data_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam logic [3:0] STARVE = 4'(STARVE_LIMIT);

    state_t      state_q,   state_d;
    logic [3:0]  count_q,   count_d;
    logic [3:0]  streak_q,  streak_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic        rw_q,      rw_d;
    logic [1:0]  width_q,   width_d;
    logic        signed_q,  signed_d;
    logic        i_ack_q,   i_ack_d;
    logic        d_ack_q,   d_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            streak_q  <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rw_q      <= `MEM_READ;
            width_q   <= `MEM_WIDTH_W;
            signed_q  <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            streak_q  <= streak_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            width_q   <= width_d;
            signed_q  <= signed_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        streak_d  = streak_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        width_d   = width_q;
        signed_d  = signed_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                // A fetch port that is not asking cannot be starved.
                if (!i_req) begin
                    streak_d = 4'd0;
                end
                if (d_req && (!i_req || (streak_q < STARVE))) begin
                    state_d  = GRANT_D;
                    count_d  = LAT_M1;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    rw_d     = d_rw;
                    width_d  = d_width;
                    signed_d = d_signed;
                    if (i_req && (streak_q != 4'hF)) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (i_req) begin
                    state_d  = GRANT_I;
                    count_d  = LAT_M1;
                    addr_d   = i_addr;
                    wdata_d  = 32'd0;
                    rw_d     = `MEM_READ;
                    width_d  = `MEM_WIDTH_W;
                    signed_d = 1'b0;
                    streak_d = 4'd0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (count_q == 4'd0) begin
                    // Final grant cycle: memory data is valid now.
                    state_d = IDLE;
                    if (state_q == GRANT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_data_out;
                    end else begin
                        d_ack_d = 1'b1;
                        if (rw_q == `MEM_READ) begin
                            d_rdata_d = mem_data_out;
                        end
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port is driven straight from the latched request; in IDLE
    // it rests at a harmless word read of address 0.
    always_comb begin
        mem_address     = 32'd0;
        mem_data_in     = 32'd0;
        mem_read_write  = `MEM_READ;
        mem_width       = `MEM_WIDTH_W;
        mem_signed_read = 1'b0;
        if (state_q != IDLE) begin
            mem_address     = addr_q;
            mem_data_in     = wdata_q;
            mem_width       = width_q;
            mem_signed_read = signed_q;
            // Write strobe only in the last grant cycle so a store aborted
            // by reset earlier in the grant never reaches memory.
            if ((state_q == GRANT_D) && (rw_q == `MEM_WRITE) && (count_q == 4'd0)) begin
                mem_read_write = `MEM_WRITE;
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                |
// | Purpose  : Self-checking bench for mem_arbiter. A byte-addressed memory |
// |            sits behind the DUT; a transaction-level model with its own |
// |            shadow memory predicts grants, acks and memory-port values.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif
`ifndef MEM_WIDTH_B
`define MEM_WIDTH_B 2'b00
`endif
`ifndef MEM_WIDTH_H
`define MEM_WIDTH_H 2'b01
`endif
`ifndef MEM_WIDTH_W
`define MEM_WIDTH_W 2'b10
`endif

module tb_mem_arbiter;

    localparam int LAT    = 2;
    localparam int STARVE = 2;

    logic        clock;
    logic        reset;
    logic        i_req, i_ack;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_rw, d_signed, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_width;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_read_write, mem_signed_read, busy;
    logic [1:0]  mem_width;

    // Second instance with single-cycle latency and a read-only memory.
    logic        l1_i_req, l1_i_ack, l1_d_req, l1_d_ack, l1_busy;
    logic [31:0] l1_i_addr, l1_i_rdata, l1_d_rdata;
    logic [31:0] l1_mem_address, l1_mem_data_in, l1_mem_data_out;
    logic        l1_mem_read_write, l1_mem_signed_read;
    logic [1:0]  l1_mem_width;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(STARVE)) u_dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_signed(d_signed), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read_write(mem_read_write), .mem_width(mem_width),
        .mem_signed_read(mem_signed_read), .mem_data_out(mem_data_out),
        .busy(busy)
    );

    mem_arbiter #(.LATENCY(1), .STARVE_LIMIT(STARVE)) u_dut_l1 (
        .clock(clock), .reset(reset),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
        .d_req(l1_d_req), .d_rw(`MEM_READ), .d_addr(32'd0), .d_wdata(32'd0),
        .d_width(`MEM_WIDTH_W), .d_signed(1'b0), .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
        .mem_address(l1_mem_address), .mem_data_in(l1_mem_data_in),
        .mem_read_write(l1_mem_read_write), .mem_width(l1_mem_width),
        .mem_signed_read(l1_mem_signed_read), .mem_data_out(l1_mem_data_out),
        .busy(l1_busy)
    );

    assign l1_mem_data_out = l1_mem_address ^ 32'hC0DE_0000;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory shared helpers ----------------
    function automatic logic [11:0] midx(input logic [31:0] a);
        return {a[24], a[10:0]};
    endfunction

    function automatic logic [31:0] shape(input logic [31:0] raw, input logic [1:0] w, input logic s);
        case (w)
            `MEM_WIDTH_B: return s ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            `MEM_WIDTH_H: return s ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default:      return raw;
        endcase
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        case (w)
            `MEM_WIDTH_B: return 1;
            `MEM_WIDTH_H: return 2;
            default:      return 4;
        endcase
    endfunction

    function automatic logic [7:0] init_byte(input int k);
        case (k)
            2048:                   return 8'h13;
            2049, 2050, 2051:       return 8'h00;
            2176, 2177, 2178, 2179: return 8'h00;
            2304:                   return 8'h80;
            default:                return 8'(k * 37 + 11);
        endcase
    endfunction

    // ---------------- memory behind the DUT ----------------
    logic [7:0] mem_b [0:4095];
    logic       mem_init;

    always @(posedge clock) begin
        if (mem_init) begin
            for (int k = 0; k < 4096; k++) mem_b[k] <= init_byte(k);
        end else if (!reset && (mem_read_write == `MEM_WRITE)) begin
            for (int k = 0; k < nbytes(mem_width); k++)
                mem_b[midx(mem_address + 32'(k))] <= mem_data_in[8*k +: 8];
        end
    end

    always_comb begin
        mem_data_out = shape({mem_b[midx(mem_address + 32'd3)], mem_b[midx(mem_address + 32'd2)],
                              mem_b[midx(mem_address + 32'd1)], mem_b[midx(mem_address)]},
                             mem_width, mem_signed_read);
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [0:4095];
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_left;    // grant cycles remaining including the current one
    int          m_streak;
    int          m_ack;     // who is acked in the current cycle
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
    logic        m_rw, m_sign;
    logic [1:0]  m_width;
    logic [5:0]  ack_bits;
    int          ack_cnt;

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] w, input logic s);
        return shape({ref_mem[midx(a + 32'd3)], ref_mem[midx(a + 32'd2)],
                      ref_mem[midx(a + 32'd1)], ref_mem[midx(a)]}, w, s);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        for (int k = 0; k < nbytes(w); k++) ref_mem[midx(a + 32'(k))] = d[8*k +: 8];
    endtask

    task automatic model_reset();
        m_owner = 0; m_left = 0; m_streak = 0; m_ack = 0;
        m_irdata = 32'd0; m_drdata = 32'd0;
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_edge();
        m_ack = 0;
        if (m_owner != 0) begin
            if (m_left == 1) begin
                if (m_owner == 1) begin
                    m_irdata = ref_read(m_addr, `MEM_WIDTH_W, 1'b0);
                    m_ack = 1;
                end else begin
                    if (m_rw == `MEM_READ) m_drdata = ref_read(m_addr, m_width, m_sign);
                    else ref_write(m_addr, m_wdata, m_width);
                    m_ack = 2;
                end
                m_owner = 0;
            end else begin
                m_left--;
            end
        end else begin
            if (!i_req) m_streak = 0;
            if (d_req && (!i_req || m_streak < STARVE)) begin
                m_owner = 2; m_left = LAT;
                m_addr = d_addr; m_wdata = d_wdata; m_rw = d_rw; m_width = d_width; m_sign = d_signed;
                if (i_req && m_streak < 15) m_streak++;
            end else if (i_req) begin
                m_owner = 1; m_left = LAT;
                m_addr = i_addr; m_wdata = 32'd0; m_rw = `MEM_READ; m_width = `MEM_WIDTH_W; m_sign = 1'b0;
                m_streak = 0;
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic exp_wr;
        exp_wr = (m_owner == 2) && (m_rw == `MEM_WRITE) && (m_left == 1);
        check_eq("busy",       32'(busy),            32'(m_owner != 0));
        check_eq("i_ack",      32'(i_ack),           32'(m_ack == 1));
        check_eq("d_ack",      32'(d_ack),           32'(m_ack == 2));
        check_eq("ack_excl",   32'(i_ack & d_ack),   32'd0);
        check_eq("i_rdata",    i_rdata,              m_irdata);
        check_eq("d_rdata",    d_rdata,              m_drdata);
        check_eq("mem_rw",     32'(mem_read_write),  32'(exp_wr));
        check_eq("mem_addr",   mem_address,          (m_owner != 0) ? m_addr : 32'd0);
        check_eq("mem_wdata",  mem_data_in,          (m_owner != 0) ? m_wdata : 32'd0);
        check_eq("mem_width",  32'(mem_width),       32'((m_owner != 0) ? m_width : `MEM_WIDTH_W));
        check_eq("mem_signed", 32'(mem_signed_read), 32'((m_owner != 0) ? m_sign : 1'b0));
    endtask

    // One clock: model and DUT cross the same edge, outputs compared mid-cycle.
    task automatic tick();
        model_edge();
        @(posedge clock);
        @(negedge clock);
        if (i_ack) begin ack_bits = {ack_bits[4:0], 1'b1}; ack_cnt++; end
        if (d_ack) begin ack_bits = {ack_bits[4:0], 1'b0}; ack_cnt++; end
        check_outputs();
    endtask

    task automatic data_access(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] w, input logic s);
        d_req = 1'b1; d_rw = rw; d_addr = a; d_wdata = wd; d_width = w; d_signed = s;
        tick();
        d_req = 1'b0;
        for (int k = 0; k < LAT; k++) tick();
    endtask

    task automatic async_reset_pulse();
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_outputs();
        @(posedge clock);
        @(negedge clock);
        check_outputs();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] w);
        logic [31:0] a;
        a = ($urandom_range(0, 1) == 1) ? 32'h0100_0000 : 32'h0000_0000;
        a = a + 32'($urandom_range(0, 2047));
        if (w == `MEM_WIDTH_W) a[1:0] = 2'b00;
        if (w == `MEM_WIDTH_H) a[0]   = 1'b0;
        return a;
    endfunction

    logic [31:0] l1_addrs [3];

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_rw = `MEM_READ; d_addr = 0; d_wdata = 0;
        d_width = `MEM_WIDTH_W; d_signed = 0;
        l1_i_req = 0; l1_i_addr = 0; l1_d_req = 0;
        ack_bits = 6'd0; ack_cnt = 0;
        for (int k = 0; k < 4096; k++) ref_mem[k] = init_byte(k);
        model_reset();
        repeat (2) @(posedge clock);
        mem_init = 1'b0;
        @(negedge clock);

        // Reset state
        check_outputs();
        check_eq("reset_i_rdata", i_rdata, 32'd0);
        check_eq("reset_mem_addr", mem_address, 32'd0);
        reset = 1'b0;

        // Fetch of word 0x13
        i_req = 1'b1; i_addr = 32'h0100_0000;
        tick();
        check_eq("fetch_busy_c1", 32'(busy), 32'd1);
        i_req = 1'b0;
        tick();
        check_eq("fetch_busy_c2", 32'(busy), 32'd1);
        tick();
        check_eq("fetch_ack", 32'(i_ack), 32'd1);
        check_eq("fetch_data", i_rdata, 32'h0000_0013);

        // Store then load back
        d_req = 1'b1; d_rw = `MEM_WRITE; d_addr = 32'h0100_0040; d_wdata = 32'hDEAD_BEEF;
        d_width = `MEM_WIDTH_W; d_signed = 1'b0;
        tick();
        check_eq("store_rw_c1", 32'(mem_read_write), 32'(`MEM_READ));
        d_req = 1'b0;
        tick();
        check_eq("store_rw_c2", 32'(mem_read_write), 32'(`MEM_WRITE));
        tick();
        check_eq("store_ack", 32'(d_ack), 32'd1);
        data_access(`MEM_READ, 32'h0100_0040, 32'd0, `MEM_WIDTH_W, 1'b0);
        check_eq("load_back", d_rdata, 32'hDEAD_BEEF);

        // Signed byte load
        data_access(`MEM_READ, 32'h0100_0100, 32'd0, `MEM_WIDTH_B, 1'b1);
        check_eq("lb_signed", d_rdata, 32'hFFFF_FF80);

        // Both ports held: starvation limit interleaves fetches
        i_req = 1'b1; i_addr = 32'h0100_0000;
        d_req = 1'b1; d_rw = `MEM_READ; d_addr = 32'h0100_0040; d_width = `MEM_WIDTH_W;
        ack_bits = 6'd0; ack_cnt = 0;
        repeat (6 * (LAT + 1)) tick();
        check_eq("starve_order", 32'(ack_bits), 32'(6'b001001));
        check_eq("starve_count", 32'(ack_cnt), 32'd6);
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // Reset during the first cycle of a store aborts it
        d_req = 1'b1; d_rw = `MEM_WRITE; d_addr = 32'h0100_0080; d_wdata = 32'hFFFF_FFFF;
        tick();
        d_req = 1'b0;
        async_reset_pulse();
        data_access(`MEM_READ, 32'h0100_0080, 32'd0, `MEM_WIDTH_W, 1'b0);
        check_eq("abort_ack", 32'(d_ack), 32'd1);
        check_eq("abort_nowrite", d_rdata, 32'h0000_0000);

        // Randomized traffic from two well-behaved masters
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                i_req = 1'b0; d_req = 1'b0;
                async_reset_pulse();
            end else begin
                if (!i_req) begin
                    if ($urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = rand_addr(`MEM_WIDTH_W); end
                end else if (i_ack) begin
                    if ($urandom_range(0, 3) == 0) i_req = 1'b0;
                    else i_addr = rand_addr(`MEM_WIDTH_W);
                end
                if (!d_req || d_ack) begin
                    if (d_req && $urandom_range(0, 3) == 0) d_req = 1'b0;
                    else if (d_req || $urandom_range(0, 1) == 0) begin
                        d_req    = 1'b1;
                        d_rw     = 1'($urandom_range(0, 1));
                        d_width  = 2'($urandom_range(0, 2));
                        d_signed = 1'($urandom_range(0, 1));
                        d_wdata  = $urandom;
                        d_addr   = rand_addr(d_width);
                    end
                end
                tick();
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 2) tick();

        // Single-cycle latency: back-to-back fetches with one idle cycle
        l1_addrs[0] = 32'h0; l1_addrs[1] = 32'h4; l1_addrs[2] = 32'h8;
        begin
            int k;
            logic [5:0] bits;
            k = 0; bits = 6'd0;
            l1_i_req = 1'b1; l1_i_addr = l1_addrs[0];
            for (int c = 0; c < 6; c++) begin
                @(posedge clock);
                @(negedge clock);
                bits = {bits[4:0], l1_i_ack};
                if (l1_i_ack && k < 3) begin
                    check_eq("l1_rdata", l1_i_rdata, l1_addrs[k] ^ 32'hC0DE_0000);
                    k++;
                    if (k < 3) l1_i_addr = l1_addrs[k];
                    else l1_i_req = 1'b0;
                end
            end
            check_eq("l1_ack_pattern", 32'(bits), 32'(6'b010101));
            check_eq("l1_ack_count", 32'(k), 32'd3);
            @(posedge clock);
            @(negedge clock);
            check_eq("l1_idle_busy", 32'(l1_busy), 32'd0);
            check_eq("l1_d_ack", 32'(l1_d_ack), 32'd0);
            check_eq("l1_d_rdata", l1_d_rdata, 32'd0);
            check_eq("l1_mem_wdata", l1_mem_data_in, 32'd0);
            check_eq("l1_mem_rw", 32'(l1_mem_read_write), 32'(`MEM_READ));
            check_eq("l1_mem_width", 32'(l1_mem_width), 32'(`MEM_WIDTH_W));
            check_eq("l1_mem_signed", 32'(l1_mem_signed_read), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, SHALL set the number of cycles one memory access occupies the memory port (legal range 1..15).
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the maximum number of consecutive data grants while a fetch request waits (legal range 1..15).
REQ-003 Ports SHALL be, as name  direction  width  meaning:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch port requests a word read.
- i_addr  in  32  fetch address.
- i_ack  out  1  one-cycle pulse: fetch access complete.
- i_rdata  out  32  fetch read data, valid while i_ack=1.
- d_req  in  1  data port requests an access.
- d_rw  in  1  data access direction, `MEM_READ or `MEM_WRITE.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_width  in  2  access width, `MEM_WIDTH_* encoding.
- d_signed  in  1  sign-extend narrow loads.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  load data, valid while d_ack=1.
- mem_address  out  32  to memory address.
- mem_data_in  out  32  to memory data_in.
- mem_read_write  out  1  to memory read_write.
- mem_width  out  2  to memory width.
- mem_signed_read  out  1  to memory signed_read.
- mem_data_out  in  32  from memory data_out.
- busy  out  1  high while an access is granted.

Function
REQ-004 FSM states SHALL be IDLE, GRANT_I, GRANT_D; busy=1 exactly in GRANT_I/GRANT_D.
REQ-005 In IDLE at a rising edge: if d_req=1 and (i_req=0 or streak<STARVE_LIMIT) go GRANT_D; else if i_req=1 go GRANT_I; else stay IDLE.
REQ-006 On entry to a grant, the arbiter SHALL latch the granted port's address, rw, wdata, width, signed into internal registers; requester inputs SHALL be ignored until the grant ends.
REQ-007 Fetch grants SHALL drive mem_read_write=`MEM_READ, mem_width=`MEM_WIDTH_W, mem_signed_read=0.
REQ-008 A grant SHALL last exactly LATENCY cycles, tracked by a down-counter loaded with LATENCY-1 on grant entry; at the edge ending the final grant cycle, the FSM SHALL return to IDLE.
REQ-009 At that edge, mem_data_out SHALL be captured into i_rdata (GRANT_I) or d_rdata (GRANT_D read), and the matching ack SHALL be 1 for the following single cycle.
REQ-010 Data writes SHALL drive mem_read_write=`MEM_WRITE only during the final grant cycle (one write edge), `MEM_READ in earlier grant cycles; d_rdata SHALL hold its previous value on a write.
REQ-011 Latency: request sampled at edge E0 -> ack high in cycle LATENCY+1 after E0; ack cycle is IDLE.
REQ-012 A req held high during its ack cycle SHALL be treated as a new request at the next edge, allowing back-to-back accesses with one idle cycle between grants.
REQ-013 Starvation counter streak (4 bits, saturating) SHALL increment on each GRANT_D entry when i_req=1, and clear on GRANT_I entry or any IDLE edge with i_req=0.
REQ-014 Simultaneous i_req and d_req with streak<STARVE_LIMIT: data wins; with streak>=STARVE_LIMIT: fetch wins.
REQ-015 In IDLE, memory outputs SHALL be mem_address=0, mem_data_in=0, mem_read_write=`MEM_READ, mem_width=`MEM_WIDTH_W, mem_signed_read=0.
REQ-016 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-017 reset=1 SHALL immediately force state IDLE, counter 0, streak 0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, and IDLE memory outputs, regardless of clock.
REQ-018 Reset asserted mid-grant SHALL abort the access with no ack; a write aborted before its final grant cycle SHALL not reach memory.
REQ-019 After reset deassertion, the first rising edge SHALL evaluate REQ-005 normally.

Verification (LATENCY=2, STARVE_LIMIT=2 unless stated)
REQ-020 i_req=1, i_addr=0x0100_0000, memory word 0x0000_0013 -> GRANT_I two cycles, i_ack=1 with i_rdata=0x0000_0013 in cycle 3, d_ack=0 throughout.
REQ-021 d_req store, d_addr=0x0100_0040, d_wdata=0xDEAD_BEEF, d_width=`MEM_WIDTH_W -> mem_read_write=`MEM_WRITE only in grant cycle 2; later load of 0x0100_0040 returns 0xDEAD_BEEF.
REQ-022 i_req and d_req held continuously -> grant order D,D,I,D,D,I; streak returns to 0 after each I grant.
REQ-023 Signed byte load of memory byte 0x80, d_signed=1, d_width=`MEM_WIDTH_B -> d_rdata=0xFFFF_FF80 on d_ack.
REQ-024 reset pulsed during grant cycle 1 of a store to 0x0100_0080 holding 0x0 -> no ack, busy=0 immediately, memory still reads 0x0.
REQ-025 LATENCY=1, i_req held with addresses 0x0,0x4,0x8 changed in each ack cycle -> i_ack every second cycle, three acks in six cycles with matching data.
